spi_als_capture: RTL and testbench

//  SPI master for the PMOD ALS (ADC081S021). It runs a burst of 16-bit read frames, extracts the
//  8-bit light sample from each frame, and writes it into the SPI port of the downstream register

---
 rtl/spi_als_capture.sv | 174 +++++++++++++++++
 tb/tb_spi_als_capture.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_als_capture.sv
// Purpose: SPI master for the PMOD ALS; bursts 16-bit reads and writes each 8-bit sample into the register bank.
// Latency: CS_SETUP + 32*CLK_DIV + 1 cycles per frame; cs_n stays high QUIET cycles between frames.
// Backpressure: none; start_i is dropped while busy_o=1 and is never queued.
module spi_als_capture #(
  parameter int N        = 8,
  parameter int CLK_DIV  = 5,
  parameter int CS_SETUP = 2,
  parameter int QUIET    = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [$clog2(N)-1:0] last_addr_i,
  input  logic                 miso_i,
  output logic                 sclk_o,
  output logic                 cs_n_o,
  output logic                 hold_ctrl_o,
  output logic                 wr_o,
  output logic [$clog2(N)-1:0] addr_o,
  output logic [31:0]          data_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int AW   = $clog2(N);
  localparam int MAXC = (CLK_DIV > CS_SETUP) ?
                        ((CLK_DIV > QUIET) ? CLK_DIV : QUIET) :
                        ((CS_SETUP > QUIET) ? CS_SETUP : QUIET);
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_STORE,
    S_QUIET,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      bit_q;
  logic [AW-1:0]   idx_q;
  logic [AW-1:0]   last_q;
  // Only bits [12:0] of the 16-bit frame are kept: the bits above are
  // leading zeros that would simply fall off the top of the shifter.
  logic [12:0]     shreg_q;
  logic [12:0]     shreg_d;
  logic            sclk_q;
  logic            cs_n_q;
  logic            hold_q;
  logic            wr_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     data_q;
  logic            busy_q;
  logic            done_q;

  // Next shift-register value: MSB-first, new bit enters at the bottom.
  always_comb begin
    shreg_d = {shreg_q[11:0], miso_i};
  end

  // Burst FSM; every output is a register updated here.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      hold_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            last_q  <= last_addr_i;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            hold_q  <= 1'b1;
            cnt_q   <= '0;
            cs_n_q  <= 1'b0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_q == CW'(CS_SETUP - 1)) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            state_q <= S_SHIFT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_SHIFT: begin
          if (cnt_q == CW'(CLK_DIV - 1)) begin
            cnt_q <= '0;
            if (!sclk_q) begin
              // Rising edge: capture the bit the ALS presented on the falling edge.
              sclk_q  <= 1'b1;
              shreg_q <= shreg_d;
            end else if (bit_q == 4'd15) begin
              // Sixteenth period complete; SCLK parks high and the sample is written.
              cs_n_q  <= 1'b1;
              wr_q    <= 1'b1;
              addr_q  <= idx_q;
              data_q  <= {24'b0, shreg_q[12:5]};
              state_q <= S_STORE;
            end else begin
              sclk_q <= 1'b0;
              bit_q  <= bit_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STORE: begin
          cnt_q <= '0;
          if (idx_q == last_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + AW'(1);
            // The STORE cycle already has cs_n high, so it counts as the
            // first of the QUIET high cycles between frames.
            if (QUIET == 1) begin
              cs_n_q  <= 1'b0;
              state_q <= S_SETUP;
            end else begin
              state_q <= S_QUIET;
            end
          end
        end
        S_QUIET: begin
          if (cnt_q == CW'(QUIET - 2)) begin
            cnt_q   <= '0;
            cs_n_q  <= 1'b0;
            state_q <= S_SETUP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          hold_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sclk_o      = sclk_q;
  assign cs_n_o      = cs_n_q;
  assign hold_ctrl_o = hold_q;
  assign wr_o        = wr_q;
  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_spi_als_capture.sv
// Purpose: directed bench for spi_als_capture with an ALS serial model and a shadow register bank.
// Latency: waits are bounded by cycle budgets; a frame is 163 cycles at default parameters.
// Backpressure: not applicable; the bench drives start pulses only.
module tb_spi_als_capture;

  localparam int N = 8;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  last_addr_i = 3'd0;
  logic        miso_i = 1'b0;
  logic        sclk_o;
  logic        cs_n_o;
  logic        hold_ctrl_o;
  logic        wr_o;
  logic [2:0]  addr_o;
  logic [31:0] data_o;
  logic        busy_o;
  logic        done_o;

  int passed = 0;
  int total  = 0;

  spi_als_capture #(.N(N), .CLK_DIV(5), .CS_SETUP(2), .QUIET(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .last_addr_i(last_addr_i),
    .miso_i(miso_i), .sclk_o(sclk_o), .cs_n_o(cs_n_o), .hold_ctrl_o(hold_ctrl_o),
    .wr_o(wr_o), .addr_o(addr_o), .data_o(data_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Frames returned by the ALS model, one per chip-select assertion.
  logic [15:0] frames [0:15];
  logic [31:0] bank   [0:N-1];
  logic [2:0]  wr_addr [0:15];
  logic [31:0] wr_data [0:15];
  logic [15:0] cur_frame = 16'h0;
  logic        clr = 1'b0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b1;
  logic        after_frame = 1'b0;
  int cyc = 0, wr_cnt = 0, wr_nohold = 0, wr_cyc = 0, done_cnt = 0, done_cyc = 0;
  int hold_bad = 0, frame_num = 0, falls = 0, rises = 0, bitpos = 16;
  int lo_runs = 0, lo_bad = 0, hi_bad = 0, rise_bad = 0, cs_low_bad = 0;
  int gap_cnt = 0, gap_bad = 0, sclk_cs_high = 0, last_cs_low = 0, cs_run = 0, sclk_run = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // ALS model, shadow bank and timing monitor, all sampled mid-cycle.
  always @(negedge clk_i) begin
    if (clr) begin
      wr_cnt = 0; wr_nohold = 0; done_cnt = 0; hold_bad = 0; frame_num = 0;
      falls = 0; rises = 0; lo_runs = 0; lo_bad = 0; hi_bad = 0; rise_bad = 0;
      cs_low_bad = 0; gap_cnt = 0; gap_bad = 0; sclk_cs_high = 0; after_frame = 1'b0;
      last_cs_low = 0; cs_run = 0; sclk_run = 0; bitpos = 16;
      for (int i = 0; i < N; i++) bank[i] = 32'hDEADBEEF;
    end else begin
      if (wr_o) begin
        if (hold_ctrl_o) bank[addr_o] = data_o;
        else wr_nohold++;
        if (wr_cnt < 16) begin
          wr_addr[wr_cnt[3:0]] = addr_o;
          wr_data[wr_cnt[3:0]] = data_o;
        end
        wr_cyc = cyc;
        wr_cnt++;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if ((busy_o || done_o) && !hold_ctrl_o) hold_bad++;
      if (!busy_o) after_frame = 1'b0;
      if (cs_n_o != prev_cs) begin
        if (!cs_n_o) begin
          if (after_frame) begin
            gap_cnt++;
            if (cs_run != 4) gap_bad++;
          end
          cur_frame = frames[frame_num[3:0]];
          frame_num++;
          falls = 0; rises = 0; bitpos = 16; miso_i = 1'b0;
        end else begin
          last_cs_low = cs_run;
          if (cs_run != 162) cs_low_bad++;
          if (rises != 16) rise_bad++;
          after_frame = 1'b1;
        end
        cs_run = 1;
      end else begin
        cs_run++;
      end
      if (sclk_o != prev_sclk) begin
        if (cs_n_o) sclk_cs_high++;
        if (sclk_o) begin
          rises++; lo_runs++;
          if (sclk_run != 5) lo_bad++;
        end else begin
          if (rises > 0 && sclk_run != 5) hi_bad++;
          falls++;
          bitpos--;
          if (bitpos >= 0) miso_i = cur_frame[bitpos[3:0]];
        end
        sclk_run = 1;
      end else begin
        sclk_run++;
      end
    end
    prev_cs = cs_n_o;
    prev_sclk = sclk_o;
  end

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk_i);
    #1 clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] la);
    @(negedge clk_i);
    last_addr_i = la;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    #1;
    total++; if (sclk_o !== 1'b1) $display("FAIL rst_sclk: got %b want 1", sclk_o); else passed++;
    total++; if (cs_n_o !== 1'b1) $display("FAIL rst_cs_n: got %b want 1", cs_n_o); else passed++;
    total++; if (hold_ctrl_o !== 1'b0) $display("FAIL rst_hold: got %b want 0", hold_ctrl_o); else passed++;
    total++; if (wr_o !== 1'b0) $display("FAIL rst_wr: got %b want 0", wr_o); else passed++;
    total++; if (addr_o !== 3'd0) $display("FAIL rst_addr: got %0d want 0", addr_o); else passed++;
    total++; if (data_o !== 32'h0) $display("FAIL rst_data: got %h want 0", data_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else passed++;
    total++; if (done_o !== 1'b0) $display("FAIL rst_done: got %b want 0", done_o); else passed++;
    reset_i = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    clear_mon();
    frames[0] = {3'b000, 8'hB3, 5'b00000};
    pulse_start(3'd0);
    wait_done(1000, ok);
    total++; if (!ok) $display("FAIL single_timeout: done_o not seen in 1000 cycles"); else passed++;
    total++; if (wr_cnt != 1) $display("FAIL single_wr_cnt: got %0d want 1", wr_cnt); else passed++;
    total++; if (wr_addr[0] !== 3'd0) $display("FAIL single_addr: got %0d want 0", wr_addr[0]); else passed++;
    total++; if (wr_data[0] !== 32'h000000B3) $display("FAIL single_data: got %h want 000000b3", wr_data[0]); else passed++;
    total++; if (done_cyc - wr_cyc != 1) $display("FAIL single_done_lag: got %0d want 1", done_cyc - wr_cyc); else passed++;
    total++; if (last_cs_low != 162) $display("FAIL single_cs_low: got %0d want 162", last_cs_low); else passed++;
    repeat (3) @(negedge clk_i);
    #1;
    total++; if (done_cnt != 1) $display("FAIL single_done_cnt: got %0d want 1", done_cnt); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy_o); else passed++;
    total++; if (hold_ctrl_o !== 1'b0) $display("FAIL single_hold_end: got %b want 0", hold_ctrl_o); else passed++;
    total++; if (hold_bad != 0) $display("FAIL single_hold: got %0d lapses want 0", hold_bad); else passed++;
  endtask

  task automatic test_burst_timing();
    bit ok;
    clear_mon();
    for (int i = 0; i < 8; i++) frames[i] = {3'b000, 8'(i + 1), 5'b00000};
    pulse_start(3'd7);
    wait_done(3000, ok);
    total++; if (!ok) $display("FAIL burst_timeout: done_o not seen in 3000 cycles"); else passed++;
    total++; if (wr_cnt != 8) $display("FAIL burst_wr_cnt: got %0d want 8", wr_cnt); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (wr_addr[i] !== 3'(i)) $display("FAIL burst_addr%0d: got %0d want %0d", i, wr_addr[i], i); else passed++;
      total++; if (bank[i] !== 32'(i + 1)) $display("FAIL burst_bank%0d: got %h want %h", i, bank[i], 32'(i + 1)); else passed++;
    end
    total++; if (hold_bad != 0) $display("FAIL burst_hold: got %0d lapses want 0", hold_bad); else passed++;
    total++; if (wr_nohold != 0) $display("FAIL burst_wr_nohold: got %0d want 0", wr_nohold); else passed++;
    total++; if (lo_runs != 128) $display("FAIL burst_rises: got %0d want 128", lo_runs); else passed++;
    total++; if (lo_bad != 0) $display("FAIL burst_sclk_low: got %0d bad want 0", lo_bad); else passed++;
    total++; if (hi_bad != 0) $display("FAIL burst_sclk_high: got %0d bad want 0", hi_bad); else passed++;
    total++; if (rise_bad != 0) $display("FAIL burst_rises_per_frame: got %0d bad want 0", rise_bad); else passed++;
    total++; if (cs_low_bad != 0) $display("FAIL burst_cs_low: got %0d bad want 0", cs_low_bad); else passed++;
    total++; if (gap_cnt != 7) $display("FAIL burst_gap_cnt: got %0d want 7", gap_cnt); else passed++;
    total++; if (gap_bad != 0) $display("FAIL burst_gap_len: got %0d bad want 0", gap_bad); else passed++;
    total++; if (sclk_cs_high != 0) $display("FAIL burst_sclk_cs_high: got %0d want 0", sclk_cs_high); else passed++;
  endtask

  task automatic test_start_ignored();
    bit ok;
    clear_mon();
    for (int i = 0; i < 8; i++) frames[i] = {3'b000, 8'(8'h40 + i), 5'b00000};
    pulse_start(3'd3);
    for (int i = 0; i < 2000 && wr_cnt < 2; i++) begin
      @(negedge clk_i);
      #1;
    end
    total++; if (wr_cnt < 2) $display("FAIL ign_wait_wr2: got %0d writes want 2", wr_cnt); else passed++;
    pulse_start(3'd7);
    wait_done(3000, ok);
    total++; if (!ok) $display("FAIL ign_timeout: done_o not seen in 3000 cycles"); else passed++;
    last_addr_i = 3'd7;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (400) @(negedge clk_i);
    #1;
    total++; if (wr_cnt != 4) $display("FAIL ign_wr_cnt: got %0d want 4", wr_cnt); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (wr_addr[i] !== 3'(i)) $display("FAIL ign_addr%0d: got %0d want %0d", i, wr_addr[i], i); else passed++;
    end
    total++; if (bank[3] !== 32'h43) $display("FAIL ign_bank3: got %h want 00000043", bank[3]); else passed++;
    total++; if (done_cnt != 1) $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); else passed++;
    total++; if (frame_num != 4) $display("FAIL ign_frames: got %0d want 4", frame_num); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL ign_busy: got %b want 0", busy_o); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_mon();
    for (int i = 0; i < 8; i++) frames[i] = {3'b000, 8'(8'h20 + i), 5'b00000};
    pulse_start(3'd7);
    for (int i = 0; i < 2000 && !(frame_num == 3 && falls == 9); i++) begin
      @(negedge clk_i);
      #1;
    end
    total++; if (!(frame_num == 3 && falls == 9)) $display("FAIL rmid_wait: frame %0d fall %0d want 3/9", frame_num, falls); else passed++;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    total++; if (cs_n_o !== 1'b1) $display("FAIL rmid_cs_n: got %b want 1", cs_n_o); else passed++;
    total++; if (sclk_o !== 1'b1) $display("FAIL rmid_sclk: got %b want 1", sclk_o); else passed++;
    total++; if (hold_ctrl_o !== 1'b0) $display("FAIL rmid_hold: got %b want 0", hold_ctrl_o); else passed++;
    total++; if (wr_o !== 1'b0) $display("FAIL rmid_wr: got %b want 0", wr_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy_o); else passed++;
    repeat (5) @(negedge clk_i);
    #1;
    total++; if (wr_cnt != 2) $display("FAIL rmid_wr_cnt: got %0d want 2", wr_cnt); else passed++;
    total++; if (bank[2] !== 32'hDEADBEEF) $display("FAIL rmid_bank2: got %h want deadbeef", bank[2]); else passed++;
    total++; if (bank[1] !== 32'h21) $display("FAIL rmid_bank1: got %h want 00000021", bank[1]); else passed++;
    reset_i = 1'b0;
    clear_mon();
    for (int i = 0; i < 8; i++) frames[i] = {3'b000, 8'(8'h30 + i), 5'b00000};
    pulse_start(3'd2);
    wait_done(2000, ok);
    total++; if (!ok) $display("FAIL rmid_re_timeout: done_o not seen in 2000 cycles"); else passed++;
    total++; if (wr_cnt != 3) $display("FAIL rmid_re_wr_cnt: got %0d want 3", wr_cnt); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (wr_addr[i] !== 3'(i)) $display("FAIL rmid_re_addr%0d: got %0d want %0d", i, wr_addr[i], i); else passed++;
      total++; if (bank[i] !== 32'(8'h30 + i)) $display("FAIL rmid_re_bank%0d: got %h want %h", i, bank[i], 32'(8'h30 + i)); else passed++;
    end
  endtask

  task automatic test_stuck_high();
    bit ok;
    clear_mon();
    frames[0] = 16'hFFFF;
    pulse_start(3'd0);
    wait_done(1000, ok);
    total++; if (!ok) $display("FAIL stuck_timeout: done_o not seen in 1000 cycles"); else passed++;
    total++; if (wr_data[0] !== 32'h000000FF) $display("FAIL stuck_data: got %h want 000000ff", wr_data[0]); else passed++;
    repeat (4) @(negedge clk_i);
    #1;
    total++; if (data_o !== 32'h000000FF) $display("FAIL stuck_data_hold: got %h want 000000ff", data_o); else passed++;
    total++; if (wr_o !== 1'b0) $display("FAIL stuck_wr_idle: got %b want 0", wr_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_timing();
    test_start_ignored();
    test_reset_mid();
    test_stuck_high();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
